// File: rtl/cache_pkg.sv
// Shared types for the cache writeback controller: FSM state encoding and
// processor access opcodes.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FILL      = 2'd2,
      FINISH    = 2'd3
   } state_t;

   localparam logic OP_LW = 1'b0;
   localparam logic OP_SW = 1'b1;

endpackage

// File: rtl/cache_perf_cnt.sv
// Saturating event counter used for cache hit/miss statistics.
module cache_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)
         count <= '0;
      else if (inc)
         count <= sat_inc(count);
   end

endmodule

// File: rtl/cache_wb_ctrl.sv
// Write-back cache controller: hit handling, dirty-line writeback, line fill
// and replay. Define CACHE_WB_CTRL_PERF_EN to add hit/miss counters.
module cache_wb_ctrl
   import cache_pkg::*;
#(
   parameter int WORDS_PER_BLOCK = 4,
   parameter int CNT_W           = 32
) (
   input  logic                               clk,
   input  logic                               rst_b,
   input  logic                               req_valid,
   input  logic                               req_we,
   input  logic                               hit,
   input  logic                               dirty,
   input  logic                               mem_ack,
   output logic                               req_ready,
   output logic                               reg_write_enable,
   output logic                               cache_we,
   output logic                               tag_we,
   output logic                               dirty_set,
   output logic                               mem_in_select,
   output logic                               mem_req,
   output logic                               mem_we,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_idx
`ifdef CACHE_WB_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0]                   hit_count,
   output logic [CNT_W-1:0]                   miss_count
`endif
);

   localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

   if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 || CNT_W < 1) begin : g_param_check
      $error("cache_wb_ctrl: WORDS_PER_BLOCK must be a power of two >= 2 and CNT_W >= 1");
   end

   state_t state;
   logic   last_word;
   logic   hit_done;
   logic   miss_start;
   logic   replay;

   assign last_word  = (word_idx == IDX_W'(WORDS_PER_BLOCK - 1));
   assign hit_done   = (state == IDLE) && req_valid && hit;
   assign miss_start = (state == IDLE) && req_valid && !hit;
   assign replay     = hit_done || ((state == FINISH) && req_valid);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state    <= IDLE;
         word_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss_start) begin
                  state    <= dirty ? WRITEBACK : FILL;
                  word_idx <= '0;
               end
            end
            WRITEBACK: begin
               if (mem_ack) begin
                  word_idx <= last_word ? '0 : word_idx + IDX_W'(1);
                  if (last_word)
                     state <= FILL;
               end
            end
            FILL: begin
               if (mem_ack) begin
                  word_idx <= last_word ? '0 : word_idx + IDX_W'(1);
                  if (last_word)
                     state <= FINISH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are forced low while reset is held so a pending hit cannot leak through.
   always_comb begin
      req_ready        = 1'b0;
      reg_write_enable = 1'b0;
      cache_we         = 1'b0;
      tag_we           = 1'b0;
      dirty_set        = 1'b0;
      mem_in_select    = 1'b0;
      mem_req          = 1'b0;
      mem_we           = 1'b0;
      if (rst_b) begin
         if (replay) begin
            req_ready = 1'b1;
            if (req_we == OP_SW) begin
               cache_we      = 1'b1;
               mem_in_select = 1'b1;
               dirty_set     = 1'b1;
            end else begin
               reg_write_enable = 1'b1;
            end
         end
         if (state == WRITEBACK) begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
         end
         if (state == FILL) begin
            mem_req  = 1'b1;
            cache_we = mem_ack;
            tag_we   = mem_ack && last_word;
         end
      end
   end

`ifdef CACHE_WB_CTRL_PERF_EN
   cache_perf_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .inc   (hit_done),
      .count (hit_count)
   );

   cache_perf_cnt #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .inc   (miss_start),
      .count (miss_count)
   );
`endif

endmodule

// File: tb/tb_cache_wb_ctrl.sv
// Directed bench for cache_wb_ctrl: IDLE vector table plus miss, reset and
// counter sequences (counter checks only with CACHE_WB_CTRL_PERF_EN).
module tb_cache_wb_ctrl;

   localparam int WPB   = 4;
   localparam int CNT_W = 2;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic req_valid = 1'b0, req_we = 1'b0, hit = 1'b0, dirty = 1'b0, mem_ack = 1'b0;
   logic req_ready, reg_write_enable, cache_we, tag_we, dirty_set, mem_in_select, mem_req, mem_we;
   logic [1:0] word_idx;
`ifdef CACHE_WB_CTRL_PERF_EN
   logic [CNT_W-1:0] hit_count, miss_count;
`endif
   logic [7:0] outv;

   int n_checks = 0;
   int n_errors = 0;

   cache_wb_ctrl #(.WORDS_PER_BLOCK(WPB), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst_b            (rst_b),
      .req_valid        (req_valid),
      .req_we           (req_we),
      .hit              (hit),
      .dirty            (dirty),
      .mem_ack          (mem_ack),
      .req_ready        (req_ready),
      .reg_write_enable (reg_write_enable),
      .cache_we         (cache_we),
      .tag_we           (tag_we),
      .dirty_set        (dirty_set),
      .mem_in_select    (mem_in_select),
      .mem_req          (mem_req),
      .mem_we           (mem_we),
      .word_idx         (word_idx)
`ifdef CACHE_WB_CTRL_PERF_EN
      ,
      .hit_count        (hit_count),
      .miss_count       (miss_count)
`endif
   );

   always #5 clk = ~clk;

   // {req_ready, reg_write_enable, cache_we, tag_we, dirty_set, mem_in_select, mem_req, mem_we}
   assign outv = {req_ready, reg_write_enable, cache_we, tag_we, dirty_set, mem_in_select, mem_req, mem_we};

   typedef struct {
      string      name;
      logic       v, we, h, d, ack;
      logic [7:0] exp0;   // outputs in the IDLE cycle
      logic [7:0] exp1;   // outputs one edge later, inputs held
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = 1'b0; req_we = 1'b0; hit = 1'b0; dirty = 1'b0; mem_ack = 1'b0;
      rst_b = 1'b0;
      #2;
      rst_b = 1'b1;
      next_cycle();
   endtask

   task automatic run_clean_miss();
      req_valid = 1'b1; req_we = 1'b0; hit = 1'b0; dirty = 1'b0; mem_ack = 1'b0;
      next_cycle();
      mem_ack = 1'b1;
      repeat (WPB) next_cycle();
      mem_ack = 1'b0;
      next_cycle();
      req_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int wb, fl, fin;
      logic ok;

      vecs[0] = '{"idle_novalid", 0, 0, 0, 0, 0, 8'b0000_0000, 8'b0000_0000};
      vecs[1] = '{"lw_hit",       1, 0, 1, 0, 0, 8'b1100_0000, 8'b1100_0000};
      vecs[2] = '{"sw_hit",       1, 1, 1, 0, 0, 8'b1010_1100, 8'b1010_1100};
      vecs[3] = '{"lw_hit_ack",   1, 0, 1, 0, 1, 8'b1100_0000, 8'b1100_0000};
      vecs[4] = '{"clean_miss",   1, 0, 0, 0, 0, 8'b0000_0000, 8'b0000_0010};
      vecs[5] = '{"dirty_miss",   1, 1, 0, 1, 0, 8'b0000_0000, 8'b0000_0011};
      vecs[6] = '{"clean_miss_ack", 1, 1, 0, 0, 1, 8'b0000_0000, 8'b0010_0010};
      vecs[7] = '{"sw_hit_dirty", 1, 1, 1, 1, 0, 8'b1010_1100, 8'b1010_1100};

      // Reset held with a pending hit: everything low.
      req_valid = 1'b1; hit = 1'b1;
      #3;
      chk("reset_outputs", outv, 8'h00);
      chk("reset_word_idx", word_idx, 0);
      do_reset();

      // Reset then LW hit.
      req_valid = 1'b1; hit = 1'b1; req_we = 1'b0;
      #4;
      chk("lw_hit_ready", req_ready, 1);
      chk("lw_hit_rwe", reg_write_enable, 1);
      chk("lw_hit_cache_we", cache_we, 0);

      for (int i = 0; i < 8; i++) begin
         do_reset();
         req_valid = vecs[i].v; req_we = vecs[i].we; hit = vecs[i].h;
         dirty = vecs[i].d; mem_ack = vecs[i].ack;
         #4;
         chk({vecs[i].name, "_c0"}, outv, vecs[i].exp0);
         next_cycle();
         #4;
         chk({vecs[i].name, "_c1"}, outv, vecs[i].exp1);
      end

      // Clean SW miss, ack every cycle (ack in IDLE must be ignored).
      do_reset();
      req_valid = 1'b1; req_we = 1'b1; hit = 1'b0; dirty = 1'b0; mem_ack = 1'b1;
      #4;
      chk("sw_miss_idle", outv, 8'h00);
      for (int i = 0; i < WPB; i++) begin
         next_cycle();
         #4;
         chk($sformatf("sw_miss_fill%0d", i), outv, (i == WPB - 1) ? 8'b0011_0010 : 8'b0010_0010);
         chk($sformatf("sw_miss_idx%0d", i), word_idx, i);
      end
      next_cycle();
      #4;
      chk("sw_miss_finish", outv, 8'b1010_1100);
      chk("sw_miss_finish_idx", word_idx, 0);
      next_cycle();
      req_valid = 1'b0; mem_ack = 1'b0;
      #4;
      chk("sw_miss_back_idle", outv, 8'h00);

      // Dirty LW miss, ack every other cycle.
      do_reset();
      req_valid = 1'b1; req_we = 1'b0; hit = 1'b0; dirty = 1'b1; mem_ack = 1'b0;
      wb = 0; fl = 0; fin = -1; ok = 1'b1;
      for (int c = 1; c <= 40 && fin < 0; c++) begin
         next_cycle();
         mem_ack = (c % 2 == 0);
         #4;
         if (mem_req && mem_we && mem_ack) begin
            if (word_idx != wb[1:0]) ok = 1'b0;
            wb++;
         end
         if (mem_req && !mem_we && mem_ack && cache_we) fl++;
         if (req_ready && reg_write_enable) fin = c;
      end
      chk("dirty_wb_acks", wb, 4);
      chk("dirty_fill_acks", fl, 4);
      chk("dirty_wb_idx", ok, 1);
      chk("dirty_latency", fin, 17);
      mem_ack = 1'b0; req_valid = 1'b0; dirty = 1'b0;
      next_cycle();

      // Stall in FILL without ack, then FINISH with req_valid dropped.
      do_reset();
      req_valid = 1'b1; req_we = 1'b0; hit = 1'b0; mem_ack = 1'b0;
      next_cycle();
      ok = 1'b1;
      repeat (6) begin
         next_cycle();
         #4;
         if (!mem_req || mem_we || word_idx != 2'd0) ok = 1'b0;
      end
      chk("fill_hold", ok, 1);
      mem_ack = 1'b1;
      repeat (WPB) next_cycle();
      req_valid = 1'b0; mem_ack = 1'b0;
      #4;
      chk("finish_novalid", outv, 8'h00);
      next_cycle();
      req_valid = 1'b1; hit = 1'b0;
      #4;
      chk("idle_after_finish", outv, 8'h00);
      req_valid = 1'b0;

      // Reset in the middle of a fill.
      do_reset();
      req_valid = 1'b1; req_we = 1'b0; hit = 1'b0; dirty = 1'b0; mem_ack = 1'b0;
      next_cycle();
      mem_ack = 1'b1;
      repeat (2) next_cycle();
      mem_ack = 1'b0;
      #2;
      chk("midfill_req", mem_req, 1);
      chk("midfill_idx", word_idx, 2);
      hit = 1'b1;
      rst_b = 1'b0;
      #1;
      chk("midfill_reset_out", outv, 8'h00);
      chk("midfill_reset_idx", word_idx, 0);
      next_cycle();
      rst_b = 1'b1;
      req_valid = 1'b0;
      #3;
      chk("post_reset_out", outv, 8'h00);
      chk("post_reset_idx", word_idx, 0);
      next_cycle();
      req_valid = 1'b1; hit = 1'b1;
      #4;
      chk("post_reset_hit", outv, 8'b1100_0000);
      req_valid = 1'b0;

`ifdef CACHE_WB_CTRL_PERF_EN
      do_reset();
      chk("perf_reset_hits", hit_count, 0);
      chk("perf_reset_misses", miss_count, 0);
      req_valid = 1'b1; req_we = 1'b0; hit = 1'b1;
      repeat (3) next_cycle();
      req_valid = 1'b0; hit = 1'b0;
      run_clean_miss();
      run_clean_miss();
      #4;
      chk("perf_hits", hit_count, 3);
      chk("perf_misses", miss_count, 2);
      req_valid = 1'b1; hit = 1'b1;
      next_cycle();
      req_valid = 1'b0; hit = 1'b0;
      #4;
      chk("perf_hit_saturate", hit_count, 3);
      chk("perf_miss_stable", miss_count, 2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cache_wb_ctrl.md
CACHE_WB_CTRL -- requirements
Module: cache_wb_ctrl

Interface
REQ-001 Parameter WORDS_PER_BLOCK, default 4, words per cache line (power of two, >= 2).
REQ-002 Parameter CNT_W, default 32, width of each performance counter.
REQ-003 Port clk input 1 clock; all state updates on the rising edge.
REQ-004 Port rst_b input 1 reset, asynchronous, active-low.
REQ-005 Port req_valid input 1 processor access pending; held stable until req_ready.
REQ-006 Port req_we input 1 access type: 1 = SW, 0 = LW.
REQ-007 Port hit input 1 tag match for the current address.
REQ-008 Port dirty input 1 dirty bit of the indexed line.
REQ-009 Port mem_ack input 1 memory accepted or returned one word this cycle.
REQ-010 Port req_ready output 1 access completes this cycle.
REQ-011 Port reg_write_enable output 1 load data is valid for the register file this cycle.
REQ-012 Port cache_we output 1 data-array word write strobe.
REQ-013 Port tag_we output 1 tag/valid write strobe, with dirty cleared.
REQ-014 Port dirty_set output 1 set the dirty bit of the indexed line.
REQ-015 Port mem_in_select output 1 cache write source: 0 = memory, 1 = processor.
REQ-016 Port mem_req output 1 memory transfer request.
REQ-017 Port mem_we output 1 memory write (writeback) when mem_req is high.
REQ-018 Port word_idx output $clog2(WORDS_PER_BLOCK) word offset of the current line transfer.

Function
REQ-019 States SHALL be IDLE, WRITEBACK, FILL and FINISH; all outputs SHALL be decoded combinationally from state and inputs.
REQ-020 IDLE with req_valid & hit SHALL assert req_ready in the same cycle, with reg_write_enable for LW, or cache_we, mem_in_select=1 and dirty_set for SW; the state SHALL remain IDLE.
REQ-021 IDLE with req_valid & !hit SHALL go to WRITEBACK if dirty, otherwise to FILL, with word_idx=0 and req_ready low.
REQ-022 WRITEBACK SHALL hold mem_req=1 and mem_we=1; each mem_ack SHALL increment word_idx; the ack at word_idx=WORDS_PER_BLOCK-1 SHALL wrap word_idx to 0 and go to FILL.
REQ-023 FILL SHALL hold mem_req=1, mem_we=0 and mem_in_select=0, and SHALL assert cache_we exactly in cycles with mem_ack; the last-word ack SHALL also assert tag_we, wrap word_idx to 0 and go to FINISH.
REQ-024 FINISH SHALL replay the access as a hit (REQ-020 outputs plus req_ready) and return to IDLE; a SW replay SHALL set dirty.
REQ-025 If req_valid is low in FINISH, the replay outputs SHALL be suppressed and the state SHALL still return to IDLE.
REQ-026 mem_ack outside WRITEBACK/FILL SHALL be ignored; with no mem_ack the state SHALL hold indefinitely (no timeout).
REQ-027 Miss latency SHALL be WORDS_PER_BLOCK ack cycles for a clean miss and 2*WORDS_PER_BLOCK for a dirty miss, plus the FINISH cycle.

Reset
REQ-028 Asserting rst_b low SHALL immediately force IDLE, word_idx=0 and all outputs 0, including in the middle of a transfer; a partially filled line SHALL keep its previous tag, since tag_we was not issued.
REQ-029 Performance counters, when present, SHALL reset to 0.

Configuration
REQ-030 With CACHE_WB_CTRL_PERF_EN defined, outputs hit_count and miss_count (CNT_W bits) SHALL increment once per access: hit_count on each IDLE hit completion, and miss_count on each IDLE-to-WRITEBACK/FILL transition; both SHALL saturate at all-ones.
REQ-031 Without CACHE_WB_CTRL_PERF_EN, these ports and their counters SHALL not exist.

Structure
REQ-032 The state enum and LW/SW opcode constants SHALL live in shared package cache_pkg.
REQ-033 The counters SHALL be one sub-module, cache_perf_cnt, instantiated twice, only under the macro.

Verification
REQ-034 Reset, then LW hit (req_valid=1, hit=1, req_we=0) -> req_ready=1 and reg_write_enable=1 in the same cycle, with cache_we=0.
REQ-035 Clean SW miss, WORDS_PER_BLOCK=4, mem_ack every cycle -> 4 FILL cycles with cache_we and word_idx 0..3, tag_we on the 4th, then FINISH with cache_we, mem_in_select=1 and dirty_set.
REQ-036 Dirty LW miss with mem_ack every other cycle -> 4 writeback acks with mem_we=1, then 4 fill acks, then reg_write_enable in FINISH; the miss takes 17 cycles from entry to FINISH.
REQ-037 rst_b pulsed low after the 2nd fill ack -> mem_req=0 asynchronously, no tag_we, IDLE, and word_idx=0 after release.
REQ-038 With PERF_EN, 3 hits and 2 misses -> hit_count=3 and miss_count=2; a forced counter value of all-ones stays all-ones on the next hit.
